fb_arbiter: RTL

Framebuffer arbiter sharing one single-port 8-bit pixel RAM between the VGA scanout path and a drawing-engine writer. It prefetches the frame linearly into a small show-ahead FIFO that feeds the pixel stream to `vga_driver`'s `color` input. Writer accesses fill the memory cycles the display does not need. It sits between the pixel RAM, the drawing engine and the VGA timing generator.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_arbiter_if.sv | 45 ++++
 rtl/fb_fifo.sv | 93 +++++++++
 rtl/fb_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fb_pkg
// Purpose  : Shared types and helpers for the framebuffer arbiter.
//            - fb_state_t : prefetch state (IDLE / RUN / DONE)
//            - PIX_W      : pixel width (RRRGGGBB)
//            - frame_size : visible pixels per frame, usable in localparams
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fb_state_t;

    function automatic int frame_size(input int h_active, input int v_active);
        return h_active * v_active;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : fb_arbiter_if
// Purpose   : Bundles the pixel stream, writer handshake and RAM port of the
//             framebuffer arbiter.
//             slave  modport : arbiter side
//             master modport : environment side (display, writer, RAM)
// Signals   : frame_start, pix_ready, pix_data, underflow,
//             wr_valid, wr_ready, wr_addr, wr_data,
//             mem_addr, mem_we, mem_wdata, mem_rdata
// Revision  : 1.0 - initial release
// ============================================================================
interface fb_arbiter_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = 19
);
    // Display side
    logic              frame_start;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              underflow;
    // Writer side
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    // RAM side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;

    modport slave (
        input  frame_start, pix_ready, wr_valid, wr_addr, wr_data, mem_rdata,
        output pix_data, underflow, wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output frame_start, pix_ready, wr_valid, wr_addr, wr_data, mem_rdata,
        input  pix_data, underflow, wr_ready, mem_addr, mem_we, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/fb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fb_fifo
// Purpose  : Synchronous show-ahead FIFO; dout always presents the head entry.
//            clear empties the FIFO and wins over push/pop in the same cycle.
// Ports    : clk, rst (async, active-high)
//            push/din  - write one entry (ignored when full without a pop)
//            pop       - drop the head entry (ignored when empty)
//            clear     - synchronous flush
//            dout      - head entry (undefined content when empty)
//            count     - number of stored entries, empty - count == 0
// Revision : 1.0 - initial release
// ============================================================================
module fb_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic      [CNT_W-1:0] count,
    output logic                  empty
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        w_do_pop  = pop && (count_q != '0);
        // A full FIFO can still accept a push when the head leaves this cycle.
        w_do_push = push && ((count_q != c_depth) || w_do_pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_arbiter
// Purpose  : Shares one single-port pixel RAM between linear frame prefetch
//            (feeding a show-ahead FIFO for scanout) and a drawing-engine
//            writer. The writer gets every cycle the prefetch does not need,
//            plus a forced slot after STARVE_MAX refused cycles when the FIFO
//            has at least two pixels of margin.
// Ports    : clk, rst (async, active-high)
//            bus (fb_arbiter_if.slave) : pixel stream, writer handshake, RAM
//            underflow_count [15:0]    : only with FB_ARBITER_STATS_EN defined
// Config   : FB_ARBITER_STATS_EN - adds the saturating underflow counter
// Revision : 1.0 - initial release
// ============================================================================
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 16,
    parameter int STARVE_MAX = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fb_arbiter_if.slave bus
`ifdef FB_ARBITER_STATS_EN
    ,
    output logic [15:0] underflow_count
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0]  c_depth      = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  c_min_margin = CNT_W'(2);
    localparam logic [SW-1:0]     c_starve_max = SW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(frame_size(H_ACTIVE, V_ACTIVE) - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    fb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              inflight_q, inflight_d;
    logic              underflow_q, underflow_d;
    logic [SW-1:0]     starve_q, starve_d;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] w_fifo_dout;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_fifo_push;
    logic             w_fifo_pop;

    // Read data of a fetch issued before frame_start belongs to the old frame.
    assign w_fifo_push = inflight_q && !bus.frame_start;
    assign w_fifo_pop  = bus.pix_ready && !w_fifo_empty;

    fb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .clear (bus.frame_start),
        .din   (bus.mem_rdata),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Port arbitration
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_fill;
    logic             w_fetch_elig;
    logic             w_writer_turn;
    logic             w_fetch;
    logic             w_pix_starved;

    always_comb begin
        // Counting the in-flight read keeps the FIFO from ever overflowing.
        w_fill        = w_fifo_count + CNT_W'(inflight_q);
        w_fetch_elig  = (state_q == RUN) && (w_fill < c_depth);
        w_writer_turn = (starve_q == c_starve_max) && (w_fill >= c_min_margin);
        // No fetch during frame_start: the address restarts at 0 next cycle.
        w_fetch       = w_fetch_elig && !w_writer_turn && !bus.frame_start;
        w_pix_starved = bus.pix_ready && w_fifo_empty;
    end

    assign bus.wr_ready  = !w_fetch;
    assign bus.mem_we    = !w_fetch && bus.wr_valid;
    assign bus.mem_addr  = w_fetch ? fetch_addr_q : bus.wr_addr;
    assign bus.mem_wdata = bus.wr_data;
    assign bus.pix_data  = w_fifo_empty ? '0 : w_fifo_dout;
    assign bus.underflow = underflow_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        inflight_d   = w_fetch;
        underflow_d  = underflow_q;
        starve_d     = starve_q;

        if (bus.frame_start) begin
            state_d      = RUN;
            fetch_addr_d = '0;
            inflight_d   = 1'b0;
            underflow_d  = 1'b0;
        end else begin
            if (w_fetch) begin
                fetch_addr_d = fetch_addr_q + ADDR_W'(1);
                if (fetch_addr_q == c_last_addr) begin
                    state_d = DONE;
                end
            end
            if (w_pix_starved) begin
                underflow_d = 1'b1;
            end
        end

        if (bus.wr_valid) begin
            if (bus.wr_ready) begin
                starve_d = '0;
            end else if (starve_q != c_starve_max) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            inflight_q   <= 1'b0;
            underflow_q  <= 1'b0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= inflight_d;
            underflow_q  <= underflow_d;
            starve_q     <= starve_d;
        end
    end

`ifdef FB_ARBITER_STATS_EN
    // Lifetime counter: only rst clears it, frame_start does not.
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (w_pix_starved && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign underflow_count = uf_cnt_q;
`endif

endmodule
`default_nettype wire
